// File: rtl/crc_unit.sv
// crc_unit: iterative reflected CRC32/CRC32C unit, 4 data bits per cycle, compute/finished handshake
module crc_unit #(
  parameter logic [31:0] POLY32  = 32'hEDB88320,
  parameter logic [31:0] POLY32C = 32'h82F63B78
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_stall_i,
  input  logic        s_flush_i,
  input  logic        s_compute_i,
  input  logic [1:0]  s_mode_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  output logic        s_finished_o,
  output logic [31:0] s_result_o
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] x_q, x_d, poly_q, poly_d, res_q, res_d, x_step, slice;
  logic [3:0]  cnt_q, cnt_d;
  logic        fin_q, fin_d;
  function automatic logic [31:0] step4(input logic [31:0] v, input logic [31:0] p);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 4; i++) r = (r >> 1) ^ (p & {32{r[0]}});
    return r;
  endfunction
  // next-state: flush wins, IDLE loads, BUSY iterates, DONE holds until the instruction leaves EX
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    poly_d  = poly_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    res_d   = res_q;
    x_step  = step4(x_q, poly_q);
    slice   = s_mode_i == 2'b00 ? {24'd0, s_op2_i[7:0]} :
              s_mode_i == 2'b01 ? {16'd0, s_op2_i[15:0]} : s_op2_i;
    if (s_flush_i) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      fin_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (s_compute_i) begin
          x_d     = s_op1_i ^ slice;
          poly_d  = s_mode_i == 2'b11 ? POLY32C : POLY32;
          cnt_d   = s_mode_i == 2'b00 ? 4'd2 : s_mode_i == 2'b01 ? 4'd4 : 4'd8;
          state_d = BUSY;
        end
        BUSY: if (!s_compute_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          x_d   = x_step;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DONE;
            fin_d   = 1'b1;
            res_d   = x_step;
          end
        end
        DONE: if (!s_compute_i || !s_stall_i) begin
          state_d = IDLE;
          fin_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      state_q <= IDLE;
      x_q     <= 32'd0;
      poly_q  <= 32'd0;
      cnt_q   <= 4'd0;
      fin_q   <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      poly_q  <= poly_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      res_q   <= res_d;
    end
  end
  assign s_finished_o = fin_q;
  assign s_result_o   = res_q;
endmodule

// File: tb/tb_crc_unit.sv
// tb_crc_unit: directed and randomized checks of crc_unit against a bitwise reflected-CRC model
module tb_crc_unit;
  localparam logic [31:0] P32  = 32'hEDB88320;
  localparam logic [31:0] P32C = 32'h82F63B78;
  logic        s_clk_i = 1'b0;
  logic        s_resetn_i = 1'b0;
  logic        s_stall_i = 1'b0;
  logic        s_flush_i = 1'b0;
  logic        s_compute_i = 1'b0;
  logic [1:0]  s_mode_i = 2'b00;
  logic [31:0] s_op1_i = 32'd0;
  logic [31:0] s_op2_i = 32'd0;
  logic        s_finished_o;
  logic [31:0] s_result_o;
  int n_chk = 0;
  int n_fail = 0;
  crc_unit dut (
    .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i), .s_stall_i(s_stall_i), .s_flush_i(s_flush_i),
    .s_compute_i(s_compute_i), .s_mode_i(s_mode_i), .s_op1_i(s_op1_i), .s_op2_i(s_op2_i),
    .s_finished_o(s_finished_o), .s_result_o(s_result_o)
  );
  always #5 s_clk_i = ~s_clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge s_clk_i);
    #1;
  endtask
  function automatic logic [31:0] crc_bits(input logic [31:0] x0, input logic [31:0] p, input int nb);
    logic [31:0] x;
    x = x0;
    for (int i = 0; i < nb; i++) x = x[0] ? (x >> 1) ^ p : x >> 1;
    return x;
  endfunction
  function automatic int nbits(input logic [1:0] m);
    return m == 2'b00 ? 8 : m == 2'b01 ? 16 : 32;
  endfunction
  function automatic logic [31:0] ref_crc(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    mask = nbits(m) == 32 ? 32'hFFFFFFFF : (32'h1 << nbits(m)) - 32'h1;
    return crc_bits(a ^ (d & mask), m == 2'b11 ? P32C : P32, nbits(m));
  endfunction
  // starts a request and counts cycles until finished; operands are scrambled after the load cycle
  task automatic run_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d,
                        input bit rnd_stall, output logic [31:0] res, output int lat);
    s_compute_i = 1'b1;
    s_mode_i = m;
    s_op1_i = a;
    s_op2_i = d;
    lat = 0;
    res = 32'd0;
    while (!s_finished_o && lat < 20) begin
      tick();
      lat++;
      s_mode_i = 2'($urandom);
      s_op1_i = $urandom;
      s_op2_i = $urandom;
      if (rnd_stall) s_stall_i = 1'($urandom);
    end
    if (!s_finished_o) chk("timeout", 32'd0, 32'd1);
    res = s_result_o;
  endtask
  task automatic leave();
    s_stall_i = 1'b0;
    s_compute_i = 1'b0;
    tick();
    chk("fin_low_after_done", 32'(s_finished_o), 32'd0);
  endtask
  logic [31:0] res, held, exp;
  int lat;
  initial begin
    tick();
    tick();
    chk("reset_fin", 32'(s_finished_o), 32'd0);
    chk("reset_res", s_result_o, 32'd0);
    s_resetn_i = 1'b1;
    tick();
    run_op(2'b00, 32'hFFFFFFFF, 32'h12345600, 1'b0, res, lat);
    chk("byte_ff_res", res, 32'h2DFD1072);
    chk("byte_lat", 32'(lat), 32'd3);
    leave();
    run_op(2'b00, 32'd0, 32'd1, 1'b0, res, lat);
    chk("byte_one_res", res, 32'h77073096);
    leave();
    exp = 32'd0;
    for (int i = 0; i < 4; i++) exp = crc_bits(exp ^ (i == 0 ? 32'd1 : 32'd0), P32C, 8);
    run_op(2'b11, 32'd0, 32'd1, 1'b0, res, lat);
    chk("crc32c_word_res", res, exp);
    chk("crc32c_word_lat", 32'(lat), 32'd9);
    leave();
    run_op(2'b01, 32'h89ABCDEF, 32'hFFFF1234, 1'b0, res, lat);
    chk("half_res", res, ref_crc(2'b01, 32'h89ABCDEF, 32'hFFFF1234));
    chk("half_lat", 32'(lat), 32'd5);
    leave();
    run_op(2'b10, 32'd0, 32'd0, 1'b0, res, lat);
    chk("zero_word_res", res, 32'd0);
    chk("zero_word_lat", 32'(lat), 32'd9);
    s_compute_i = 1'b1;
    s_stall_i = 1'b0;
    s_mode_i = 2'b10;
    s_op1_i = 32'd0;
    s_op2_i = 32'd0;
    tick();
    chk("b2b_gap_fin", 32'(s_finished_o), 32'd0);
    run_op(2'b10, 32'h12345678, 32'hCAFEF00D, 1'b0, res, lat);
    chk("b2b_res", res, ref_crc(2'b10, 32'h12345678, 32'hCAFEF00D));
    chk("b2b_lat", 32'(lat), 32'd9);
    held = res;
    s_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_fin", 32'(s_finished_o), 32'd1);
      chk("stall_res", s_result_o, held);
    end
    leave();
    s_compute_i = 1'b1;
    s_mode_i = 2'b10;
    s_op1_i = $urandom;
    s_op2_i = $urandom;
    for (int i = 0; i < 3; i++) tick();
    s_flush_i = 1'b1;
    tick();
    s_flush_i = 1'b0;
    s_compute_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("flush_no_fin", 32'(s_finished_o), 32'd0);
      tick();
    end
    run_op(2'b00, 32'd0, 32'd1, 1'b0, res, lat);
    chk("post_flush_res", res, 32'h77073096);
    chk("post_flush_lat", 32'(lat), 32'd3);
    leave();
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, res, lat);
    leave();
    s_compute_i = 1'b1;
    s_mode_i = 2'b10;
    tick();
    tick();
    s_resetn_i = 1'b0;
    tick();
    chk("rst_busy_fin", 32'(s_finished_o), 32'd0);
    chk("rst_busy_res", s_result_o, 32'd0);
    s_resetn_i = 1'b1;
    s_compute_i = 1'b0;
    tick();
    for (int k = 0; k < 1000; k++) begin
      logic [1:0] m;
      logic [31:0] a, d;
      int fl_at;
      bit aborted;
      m = 2'($urandom);
      a = $urandom;
      d = $urandom;
      exp = ref_crc(m, a, d);
      fl_at = $urandom_range(0, 7) == 0 ? $urandom_range(1, nbits(m) / 4) : 0;
      aborted = 1'b0;
      s_compute_i = 1'b1;
      s_mode_i = m;
      s_op1_i = a;
      s_op2_i = d;
      lat = 0;
      while (!s_finished_o && lat < 20 && !aborted) begin
        s_flush_i = (fl_at != 0 && lat == fl_at);
        tick();
        if (s_flush_i) begin
          s_flush_i = 1'b0;
          s_compute_i = 1'b0;
          chk("rnd_flush_fin", 32'(s_finished_o), 32'd0);
          tick();
          chk("rnd_flush_idle", 32'(s_finished_o), 32'd0);
          aborted = 1'b1;
        end else begin
          lat++;
          s_mode_i = 2'($urandom);
          s_op1_i = $urandom;
          s_op2_i = $urandom;
          s_stall_i = 1'($urandom);
        end
      end
      if (!aborted) begin
        chk("rnd_fin", 32'(s_finished_o), 32'd1);
        chk("rnd_res", s_result_o, exp);
        chk("rnd_lat", 32'(lat), 32'(nbits(m) / 4 + 1));
        s_stall_i = 1'b1;
        for (int i = $urandom_range(0, 2); i > 0; i--) begin
          tick();
          chk("rnd_hold_res", s_result_o, exp);
        end
        leave();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
